// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: configurable UART receiver.
// Data width, optional parity, one or two stop bits and a runtime baud divisor.
// The RX pin is synchronised, a start bit is detected on its falling edge, and each
// bit is sampled near its middle by a down-counter. False starts are rejected.
// rdy, parity_err, frame_err and overrun are held until clr_rdy is pulsed.
module uart_rx_cfg #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1,
    parameter int DIV_W      = 13
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 RX,
    input  logic [DIV_W-1:0]     baud_div,
    input  logic                 clr_rdy,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rdy,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t state;
    state_t state_next;

    logic                 sync1;
    logic                 sync2;
    logic                 rx_prev;
    logic [DIV_W-1:0]     div_q;
    logic [DIV_W-1:0]     cnt;
    logic [3:0]           bit_cnt;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 perr_q;
    logic                 ferr_q;

    logic start_det;
    logic cnt_zero;
    logic last_data;
    logic last_stop;
    logic par_bad;

    // A start is a synchronised high-to-low transition seen while idle.
    assign start_det = (state == S_IDLE) && rx_prev && !sync2;
    assign cnt_zero  = (cnt == '0);
    assign last_data = (bit_cnt == 4'(DATA_BITS - 1));
    assign last_stop = (state == S_STOP) && cnt_zero && (bit_cnt == 4'(STOP_BITS - 1));
    // Parity is bad when the total count of ones (data plus parity bit) disagrees
    // with the selected sense: odd total for even parity, even total for odd parity.
    assign par_bad   = (^shift_reg) ^ sync2 ^ (PARITY_ODD != 0);
    assign busy      = (state != S_IDLE);

    // State register; reset aborts any frame in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; every bit phase advances only on a mid-bit sample.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (start_det) begin
                    state_next = S_START;
                end
            end
            S_START: begin
                if (cnt_zero) begin
                    state_next = sync2 ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (cnt_zero && last_data) begin
                    state_next = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                if (cnt_zero) begin
                    state_next = S_STOP;
                end
            end
            S_STOP: begin
                if (last_stop) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Input synchroniser, baud counter, bit counter and shift register.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1     <= 1'b1;
            sync2     <= 1'b1;
            rx_prev   <= 1'b1;
            div_q     <= '0;
            cnt       <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            sync1   <= RX;
            sync2   <= sync1;
            rx_prev <= sync2;
            if (start_det) begin
                div_q   <= baud_div;
                cnt     <= baud_div >> 1;
                bit_cnt <= '0;
                perr_q  <= 1'b0;
                ferr_q  <= 1'b0;
            end else if (state != S_IDLE) begin
                if (cnt_zero) begin
                    cnt <= div_q - DIV_W'(1);
                    case (state)
                        S_START: begin
                            bit_cnt <= '0;
                        end
                        S_DATA: begin
                            shift_reg <= {sync2, shift_reg[DATA_BITS-1:1]};
                            bit_cnt   <= last_data ? 4'd0 : bit_cnt + 4'd1;
                        end
                        S_PARITY: begin
                            perr_q <= par_bad;
                        end
                        S_STOP: begin
                            ferr_q  <= ferr_q | ~sync2;
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                        default: begin
                            bit_cnt <= bit_cnt;
                        end
                    endcase
                end else begin
                    cnt <= cnt - DIV_W'(1);
                end
            end
        end
    end

    // Host-facing outputs; a completing frame takes priority over clr_rdy.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_data    <= '0;
            rdy        <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else if (last_stop) begin
            rx_data    <= shift_reg;
            rdy        <= 1'b1;
            parity_err <= (PARITY_EN != 0) ? perr_q : 1'b0;
            frame_err  <= ferr_q | ~sync2;
            overrun    <= rdy & ~clr_rdy;
        end else if (clr_rdy) begin
            rdy        <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg: self-checking bench for uart_rx_cfg.
// Four receivers share one serial line: 8N1, 8E1, 8N2 and 9N1. Each directed or
// random frame targets one of them, selected by sel, and is compared with a
// frame-level reference model.
module tb_uart_rx_cfg;

    logic        clk = 1'b0;
    logic        rst;
    logic        RX;
    logic        clr_rdy;
    logic [12:0] baud_div;

    logic [7:0]  d_a;
    logic [7:0]  d_p;
    logic [7:0]  d_s;
    logic [8:0]  d_n;
    logic [3:0]  rdy_v;
    logic [3:0]  pe_v;
    logic [3:0]  fe_v;
    logic [3:0]  ov_v;
    logic [3:0]  busy_v;

    int          sel;
    logic [15:0] o_data;
    logic        o_rdy;
    logic        o_pe;
    logic        o_fe;
    logic        o_ov;
    logic        o_busy;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    uart_rx_cfg #(.DATA_BITS(8)) u_a (
        .clk(clk), .rst(rst), .RX(RX), .baud_div(baud_div), .clr_rdy(clr_rdy),
        .rx_data(d_a), .rdy(rdy_v[0]), .parity_err(pe_v[0]), .frame_err(fe_v[0]),
        .overrun(ov_v[0]), .busy(busy_v[0]));

    uart_rx_cfg #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0)) u_p (
        .clk(clk), .rst(rst), .RX(RX), .baud_div(baud_div), .clr_rdy(clr_rdy),
        .rx_data(d_p), .rdy(rdy_v[1]), .parity_err(pe_v[1]), .frame_err(fe_v[1]),
        .overrun(ov_v[1]), .busy(busy_v[1]));

    uart_rx_cfg #(.DATA_BITS(8), .STOP_BITS(2)) u_s (
        .clk(clk), .rst(rst), .RX(RX), .baud_div(baud_div), .clr_rdy(clr_rdy),
        .rx_data(d_s), .rdy(rdy_v[2]), .parity_err(pe_v[2]), .frame_err(fe_v[2]),
        .overrun(ov_v[2]), .busy(busy_v[2]));

    uart_rx_cfg #(.DATA_BITS(9)) u_n (
        .clk(clk), .rst(rst), .RX(RX), .baud_div(baud_div), .clr_rdy(clr_rdy),
        .rx_data(d_n), .rdy(rdy_v[3]), .parity_err(pe_v[3]), .frame_err(fe_v[3]),
        .overrun(ov_v[3]), .busy(busy_v[3]));

    // Route the currently targeted receiver onto a common set of observation signals.
    always_comb begin
        o_data = {7'h0, d_n};
        case (sel)
            0: o_data = {8'h0, d_a};
            1: o_data = {8'h0, d_p};
            2: o_data = {8'h0, d_s};
            default: o_data = {7'h0, d_n};
        endcase
        o_rdy  = rdy_v[sel[1:0]];
        o_pe   = pe_v[sel[1:0]];
        o_fe   = fe_v[sel[1:0]];
        o_ov   = ov_v[sel[1:0]];
        o_busy = busy_v[sel[1:0]];
    end

    function automatic int nb_of(input int s);
        return (s == 3) ? 9 : 8;
    endfunction

    function automatic bit pen_of(input int s);
        return (s == 1);
    endfunction

    function automatic int ns_of(input int s);
        return (s == 2) ? 2 : 1;
    endfunction

    // Frame-level reference: what a receiver of format s should report for this line content.
    function automatic void ref_frame(input int s, input logic [15:0] data, input logic pbit,
                                      input logic [1:0] stops, output logic [15:0] exp_d,
                                      output logic exp_pe, output logic exp_fe);
        int ones;
        ones  = 0;
        exp_d = 16'h0;
        for (int i = 0; i < nb_of(s); i++) begin
            exp_d[i] = data[i];
            ones += int'(data[i]);
        end
        exp_pe = pen_of(s) && (((ones + int'(pbit)) % 2) != 0);
        exp_fe = 1'b0;
        for (int i = 0; i < ns_of(s); i++) begin
            if (stops[i] == 1'b0) exp_fe = 1'b1;
        end
    endfunction

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        checks++;
        assert (obs === exp_v)
        else begin
            fails++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Drive one frame onto RX, starting right now (just after a rising edge).
    // baud_div is disturbed during the data bits to show it is only captured at start.
    task automatic applyStimulus(input logic [15:0] data, input int nb, input bit pen,
                                 input logic pbit, input int ns, input logic [1:0] stops,
                                 input int div, input int nsend, input logic idle_val);
        logic q[$];
        q.push_back(1'b0);
        for (int i = 0; i < nb; i++) q.push_back(data[i]);
        if (pen) q.push_back(pbit);
        for (int i = 0; i < ns; i++) q.push_back(stops[i]);
        baud_div = 13'(div);
        for (int i = 0; i < q.size() && i < nsend; i++) begin
            RX = q[i];
            if (i == 1) baud_div = 13'($urandom_range(4, 40));
            if (i == 5) baud_div = 13'(div);
            repeat (div) @(posedge clk);
            #1;
        end
        baud_div = 13'(div);
        if (nsend >= q.size()) RX = idle_val;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic pulse_clear();
        clr_rdy = 1'b1;
        @(posedge clk);
        #1;
        clr_rdy = 1'b0;
    endtask

    task automatic clear_and_check(input string tag);
        pulse_clear();
        checkOutput({tag, "_clr_rdy"}, 16'(o_rdy), 16'h0);
        checkOutput({tag, "_clr_fe"}, 16'(o_fe), 16'h0);
        checkOutput({tag, "_clr_pe"}, 16'(o_pe), 16'h0);
        checkOutput({tag, "_clr_ov"}, 16'(o_ov), 16'h0);
    endtask

    // Idle long enough for every receiver to settle, clear, send one frame to
    // receiver sel and compare against the reference model.
    task automatic receive_and_check(input string tag, input logic [15:0] data, input logic pbit,
                                     input logic [1:0] stops, input int div, input logic idle_val);
        logic [15:0] exp_d;
        logic        exp_pe;
        logic        exp_fe;
        int          k;
        repeat (450) @(posedge clk);
        #1;
        pulse_clear();
        applyStimulus(data, nb_of(sel), pen_of(sel), pbit, ns_of(sel), stops, div, 99, idle_val);
        k = 0;
        while (k < 20 * div && o_rdy !== 1'b1) begin
            @(posedge clk);
            #1;
            k++;
        end
        ref_frame(sel, data, pbit, stops, exp_d, exp_pe, exp_fe);
        checkOutput({tag, "_rdy"}, 16'(o_rdy), 16'h1);
        checkOutput({tag, "_data"}, o_data, exp_d);
        checkOutput({tag, "_pe"}, 16'(o_pe), 16'(exp_pe));
        checkOutput({tag, "_fe"}, 16'(o_fe), 16'(exp_fe));
        checkOutput({tag, "_ov"}, 16'(o_ov), 16'h0);
    endtask

    initial begin
        int          lat;
        int          lat5;
        logic        busy_seen;
        logic [15:0] rdata;
        logic [1:0]  rstops;
        logic        rpbit;
        int          rdiv;

        sel      = 0;
        RX       = 1'b1;
        rst      = 1'b1;
        clr_rdy  = 1'b0;
        baud_div = 13'd16;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        checkOutput("reset_rdy", 16'(o_rdy), 16'h0);
        checkOutput("reset_data", o_data, 16'h0);
        checkOutput("reset_fe", 16'(o_fe), 16'h0);
        checkOutput("reset_pe", 16'(o_pe), 16'h0);
        checkOutput("reset_ov", 16'(o_ov), 16'h0);
        checkOutput("reset_busy", 16'(o_busy), 16'h0);

        // T1: 0xA5 8N1 at divisor 16, with completion latency near 152 clocks
        repeat (20) @(posedge clk);
        #1;
        lat = 0;
        fork
            applyStimulus(16'hA5, 8, 1'b0, 1'b0, 1, 2'b11, 16, 99, 1'b1);
            begin
                while (lat < 400 && o_rdy !== 1'b1) begin
                    @(posedge clk);
                    #1;
                    lat++;
                end
            end
        join
        checkOutput("t1_latency_window", 16'(lat >= 148 && lat <= 160), 16'h1);
        checkOutput("t1_rdy", 16'(o_rdy), 16'h1);
        checkOutput("t1_data", o_data, 16'h00A5);
        checkOutput("t1_fe", 16'(o_fe), 16'h0);
        checkOutput("t1_pe", 16'(o_pe), 16'h0);
        checkOutput("t1_ov", 16'(o_ov), 16'h0);
        clear_and_check("t1");

        // T2: even parity, wrong then right parity bit
        sel = 1;
        receive_and_check("t2_badpar", 16'h3C, 1'b1, 2'b11, 16, 1'b1);
        receive_and_check("t2_goodpar", 16'h3C, 1'b0, 2'b11, 16, 1'b1);

        // T3: two stop bits, second one low, then a held-low break
        sel = 2;
        receive_and_check("t3_break", 16'h55, 1'b0, 2'b01, 16, 1'b0);
        clear_and_check("t3");
        repeat (80) @(posedge clk);
        #1;
        checkOutput("t3_held_low_rdy", 16'(o_rdy), 16'h0);
        checkOutput("t3_held_low_busy", 16'(o_busy), 16'h0);
        RX = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        checkOutput("t3_release_rdy", 16'(o_rdy), 16'h0);
        receive_and_check("t3_clean", 16'hC3, 1'b0, 2'b11, 16, 1'b1);

        // T4: 4-clock low glitch is rejected as a false start
        sel = 0;
        do_reset();
        repeat (20) @(posedge clk);
        #1;
        baud_div  = 13'd16;
        busy_seen = 1'b0;
        RX        = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        RX = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (o_busy === 1'b1) busy_seen = 1'b1;
        end
        checkOutput("t4_busy_pulsed", 16'(busy_seen), 16'h1);
        checkOutput("t4_busy_after", 16'(o_busy), 16'h0);
        checkOutput("t4_rdy", 16'(o_rdy), 16'h0);
        checkOutput("t4_fe", 16'(o_fe), 16'h0);
        checkOutput("t4_pe", 16'(o_pe), 16'h0);

        // T5: overrun, then clr_rdy exactly on the completion cycle
        do_reset();
        repeat (20) @(posedge clk);
        #1;
        lat5 = 0;
        fork
            applyStimulus(16'h11, 8, 1'b0, 1'b0, 1, 2'b11, 16, 99, 1'b1);
            begin
                while (lat5 < 400 && o_rdy !== 1'b1) begin
                    @(posedge clk);
                    #1;
                    lat5++;
                end
            end
        join
        checkOutput("t5_first_rdy", 16'(o_rdy), 16'h1);
        repeat (450) @(posedge clk);
        #1;
        applyStimulus(16'h22, 8, 1'b0, 1'b0, 1, 2'b11, 16, 99, 1'b1);
        checkOutput("t5_ovr_rdy", 16'(o_rdy), 16'h1);
        checkOutput("t5_ovr_data", o_data, 16'h0022);
        checkOutput("t5_ovr_flag", 16'(o_ov), 16'h1);
        do_reset();
        repeat (20) @(posedge clk);
        #1;
        applyStimulus(16'h11, 8, 1'b0, 1'b0, 1, 2'b11, 16, 99, 1'b1);
        repeat (450) @(posedge clk);
        #1;
        fork
            applyStimulus(16'h22, 8, 1'b0, 1'b0, 1, 2'b11, 16, 99, 1'b1);
            begin
                repeat (lat5 - 1) @(posedge clk);
                #1 clr_rdy = 1'b1;
                @(posedge clk);
                #1 clr_rdy = 1'b0;
            end
        join
        checkOutput("t5_sameclr_rdy", 16'(o_rdy), 16'h1);
        checkOutput("t5_sameclr_ov", 16'(o_ov), 16'h0);
        checkOutput("t5_sameclr_data", o_data, 16'h0022);

        // T6: reset in the middle of a data phase, then clean 8-bit and 9-bit frames
        do_reset();
        receive_and_check("t6_pre", 16'h5A, 1'b0, 2'b11, 16, 1'b1);
        repeat (450) @(posedge clk);
        #1;
        applyStimulus(16'h9C, 8, 1'b0, 1'b0, 1, 2'b11, 16, 5, 1'b1);
        repeat (8) @(posedge clk);
        #1;
        checkOutput("t6_busy_mid", 16'(o_busy), 16'h1);
        RX  = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("t6_rst_busy", 16'(o_busy), 16'h0);
        checkOutput("t6_rst_rdy", 16'(o_rdy), 16'h0);
        checkOutput("t6_rst_data", o_data, 16'h0);
        receive_and_check("t6_clean", 16'h9C, 1'b0, 2'b11, 16, 1'b1);
        sel = 3;
        receive_and_check("t6_nine", 16'h1AB, 1'b0, 2'b11, 16, 1'b1);

        // Randomised frames across all four formats
        do_reset();
        for (int r = 0; r < 16; r++) begin
            sel    = r % 4;
            rdata  = 16'($urandom);
            rpbit  = 1'($urandom_range(0, 1));
            rstops = {1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0)};
            rdiv   = int'($urandom_range(10, 30));
            receive_and_check($sformatf("rand%0d", r), rdata, rpbit, rstops, rdiv, 1'b1);
            clear_and_check($sformatf("rand%0d", r));
        end

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
